// File: rtl/io_in_debounce.sv
// Input-pad conditioner: synchronizes an asynchronous pin into real_clk, debounces it with a
// stability counter and reports the accepted level, edge strobes and a saturating edge count.
module io_in_debounce #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8,
   parameter logic        INIT            = 1'b0
) (
   input  logic             real_clk,
   input  logic             real_rst,
   input  logic             pin_in,
   input  logic             en,
   input  logic             clr_cnt,
   output logic             level,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] edge_cnt,
   output logic             busy
);

   localparam int unsigned StabW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [StabW-1:0] StabLast = StabW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [StabW-1:0]       stab_q, stab_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
   logic                   s_out;
   logic                   accept;

   // Only the next stage taps sync_q[0]; the decision logic sees the last stage alone.
   assign s_out = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], pin_in};
      stab_d     = '0;
      level_d    = level_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      accept     = 1'b0;
      edge_cnt_d = edge_cnt_q;

      if (en && (s_out != level_q)) begin
         if (stab_q == StabLast) begin
            level_d = s_out;
            accept  = 1'b1;
            rise_d  = s_out;
            fall_d  = ~s_out;
         end else begin
            stab_d = stab_q + 1'b1;
         end
      end

      // A clear wins over a transition accepted on the same edge.
      if (clr_cnt) begin
         edge_cnt_d = '0;
      end else if (accept && (edge_cnt_q != '1)) begin
         edge_cnt_d = edge_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge real_clk or posedge real_rst) begin
      if (real_rst) begin
         sync_q     <= {SYNC_STAGES{INIT}};
         stab_q     <= '0;
         level_q    <= INIT;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         edge_cnt_q <= '0;
      end else begin
         sync_q     <= sync_d;
         stab_q     <= stab_d;
         level_q    <= level_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         edge_cnt_q <= edge_cnt_d;
      end
   end

   assign level    = level_q;
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign edge_cnt = edge_cnt_q;
   assign busy     = (stab_q != '0);

endmodule

// File: tb/tb_io_in_debounce.sv
// Directed bench for io_in_debounce: default instance, a CNT_W=3 instance for saturation and a
// DEBOUNCE_CYCLES=1 instance, all driven from the same pin/enable/clear stimulus.
module tb_io_in_debounce;

   logic       real_clk;
   logic       real_rst;
   logic       pin_in;
   logic       en;
   logic       clr_cnt;

   logic       d_level, d_rise, d_fall, d_busy;
   logic [7:0] d_edge_cnt;
   logic       s_level, s_rise, s_fall, s_busy;
   logic [2:0] s_edge_cnt;
   logic       o_level, o_rise, o_fall, o_busy;
   logic [7:0] o_edge_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int rise_n;
   int fall_n;
   logic both_seen;

   io_in_debounce dut_d (
      .real_clk (real_clk),
      .real_rst (real_rst),
      .pin_in   (pin_in),
      .en       (en),
      .clr_cnt  (clr_cnt),
      .level    (d_level),
      .rise     (d_rise),
      .fall     (d_fall),
      .edge_cnt (d_edge_cnt),
      .busy     (d_busy)
   );

   io_in_debounce #(.CNT_W(3)) dut_s (
      .real_clk (real_clk),
      .real_rst (real_rst),
      .pin_in   (pin_in),
      .en       (en),
      .clr_cnt  (clr_cnt),
      .level    (s_level),
      .rise     (s_rise),
      .fall     (s_fall),
      .edge_cnt (s_edge_cnt),
      .busy     (s_busy)
   );

   io_in_debounce #(.DEBOUNCE_CYCLES(1)) dut_o (
      .real_clk (real_clk),
      .real_rst (real_rst),
      .pin_in   (pin_in),
      .en       (en),
      .clr_cnt  (clr_cnt),
      .level    (o_level),
      .rise     (o_rise),
      .fall     (o_fall),
      .edge_cnt (o_edge_cnt),
      .busy     (o_busy)
   );

   initial real_clk = 1'b0;
   always #5 real_clk = ~real_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance n rising edges, leaving time 1 unit past the last edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge real_clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      real_rst = 1'b1;
      pin_in   = 1'b0;
      en       = 1'b1;
      clr_cnt  = 1'b0;

      #3;
      chk("rst_level", 32'(d_level), 0);
      chk("rst_rise", 32'(d_rise), 0);
      chk("rst_fall", 32'(d_fall), 0);
      chk("rst_edge_cnt", 32'(d_edge_cnt), 0);
      chk("rst_busy", 32'(d_busy), 0);
      tick(2);
      real_rst = 1'b0;
      tick(2);

      // Clean 0->1: accepted on edge 6, busy after edges 3..5.
      pin_in = 1'b1;
      tick(2);
      chk("t1_busy_e2", 32'(d_busy), 0);
      chk("t1_o_level_e2", 32'(o_level), 0);
      tick(1);
      chk("t1_busy_e3", 32'(d_busy), 1);
      chk("t1_o_level_e3", 32'(o_level), 1);
      chk("t1_o_rise_e3", 32'(o_rise), 1);
      chk("t1_o_fall_e3", 32'(o_fall), 0);
      chk("t1_o_busy_e3", 32'(o_busy), 0);
      chk("t1_o_edge_cnt", 32'(o_edge_cnt), 1);
      tick(1);
      chk("t1_busy_e4", 32'(d_busy), 1);
      tick(1);
      chk("t1_busy_e5", 32'(d_busy), 1);
      chk("t1_level_e5", 32'(d_level), 0);
      tick(1);
      chk("t1_level_e6", 32'(d_level), 1);
      chk("t1_rise_e6", 32'(d_rise), 1);
      chk("t1_fall_e6", 32'(d_fall), 0);
      chk("t1_busy_e6", 32'(d_busy), 0);
      chk("t1_edge_cnt", 32'(d_edge_cnt), 1);
      tick(1);
      chk("t1_rise_e7", 32'(d_rise), 0);
      chk("t1_level_e7", 32'(d_level), 1);

      // Clean 1->0 so the glitch test starts from level 0.
      pin_in = 1'b0;
      tick(5);
      chk("t2_level_e5", 32'(d_level), 1);
      tick(1);
      chk("t2_level_e6", 32'(d_level), 0);
      chk("t2_fall_e6", 32'(d_fall), 1);
      chk("t2_rise_e6", 32'(d_rise), 0);
      chk("t2_edge_cnt", 32'(d_edge_cnt), 2);
      tick(1);
      chk("t2_fall_e7", 32'(d_fall), 0);

      // Pin high for exactly 3 sampled edges must be rejected.
      pin_in = 1'b1;
      tick(3);
      pin_in = 1'b0;
      tick(2);
      chk("t3_busy_peak", 32'(d_busy), 1);
      rise_n = 0;
      for (int i = 0; i < 8; i++) begin
         rise_n += int'(d_rise);
         tick(1);
      end
      chk("t3_no_rise", 32'(rise_n), 0);
      chk("t3_level", 32'(d_level), 0);
      chk("t3_edge_cnt", 32'(d_edge_cnt), 2);
      chk("t3_busy_idle", 32'(d_busy), 0);

      // Ten clean toggles, CNT_W=3 saturates at 7.
      clr_cnt = 1'b1;
      tick(1);
      clr_cnt = 1'b0;
      chk("t4_clr_s", 32'(s_edge_cnt), 0);
      rise_n    = 0;
      fall_n    = 0;
      both_seen = 1'b0;
      for (int t = 0; t < 10; t++) begin
         pin_in = ~pin_in;
         for (int c = 0; c < 8; c++) begin
            tick(1);
            rise_n += int'(s_rise);
            fall_n += int'(s_fall);
            if (s_rise && s_fall) both_seen = 1'b1;
         end
      end
      chk("t4_rise_pulses", 32'(rise_n), 5);
      chk("t4_fall_pulses", 32'(fall_n), 5);
      chk("t4_both_strobes", 32'(both_seen), 0);
      chk("t4_sat", 32'(s_edge_cnt), 7);
      chk("t4_d_cnt", 32'(d_edge_cnt), 10);
      chk("t4_s_level", 32'(s_level), 0);
      tick(8);
      chk("t4_sat_hold", 32'(s_edge_cnt), 7);
      chk("t4_s_busy", 32'(s_busy), 0);
      clr_cnt = 1'b1;
      tick(1);
      clr_cnt = 1'b0;
      chk("t4_clr_after", 32'(s_edge_cnt), 0);

      // Clear on the same edge as an accepted rise.
      pin_in = 1'b1;
      tick(5);
      chk("t5_level_e5", 32'(d_level), 0);
      clr_cnt = 1'b1;
      tick(1);
      clr_cnt = 1'b0;
      chk("t5_rise", 32'(d_rise), 1);
      chk("t5_level", 32'(d_level), 1);
      chk("t5_edge_cnt", 32'(d_edge_cnt), 0);
      tick(1);
      chk("t5_edge_cnt_after", 32'(d_edge_cnt), 0);
      chk("t5_rise_after", 32'(d_rise), 0);

      // Drop en with the counter at 2; acceptance must take 4 full edges after re-enable.
      pin_in = 1'b0;
      tick(8);
      chk("t6_pre_level", 32'(d_level), 0);
      pin_in = 1'b1;
      tick(4);
      chk("t6_busy_cnt2", 32'(d_busy), 1);
      en = 1'b0;
      tick(5);
      chk("t6_busy_dis", 32'(d_busy), 0);
      chk("t6_level_dis", 32'(d_level), 0);
      en = 1'b1;
      tick(3);
      chk("t6_level_e3", 32'(d_level), 0);
      chk("t6_busy_e3", 32'(d_busy), 1);
      tick(1);
      chk("t6_level_e4", 32'(d_level), 1);
      chk("t6_rise_e4", 32'(d_rise), 1);

      // Asynchronous reset mid-count, then full latency after release.
      pin_in = 1'b0;
      tick(8);
      chk("t7_pre_level", 32'(d_level), 0);
      pin_in = 1'b1;
      tick(4);
      chk("t7_busy_pre", 32'(d_busy), 1);
      #2;
      real_rst = 1'b1;
      #1;
      chk("t7_rst_level", 32'(d_level), 0);
      chk("t7_rst_busy", 32'(d_busy), 0);
      chk("t7_rst_edge_cnt", 32'(d_edge_cnt), 0);
      chk("t7_rst_fall", 32'(d_fall), 0);
      tick(1);
      real_rst = 1'b0;
      tick(5);
      chk("t7_level_e5", 32'(d_level), 0);
      tick(1);
      chk("t7_level_e6", 32'(d_level), 1);
      chk("t7_rise_e6", 32'(d_rise), 1);
      chk("t7_edge_cnt", 32'(d_edge_cnt), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/io_in_debounce.md
Name: io_in_debounce

Overview:
- Conditions one input-pad fan-out pin (e.g. pin_0) before core logic uses it.
- Synchronizes the asynchronous pad level into the real_clk domain and debounces it with a stability counter.
- Produces a clean level, single-cycle rise/fall strobes and a saturating transition counter.
- Sits directly downstream of the 1-bit input pad; one instance per pad pin consumed by the core.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal ≥2.
- DEBOUNCE_CYCLES, 4, consecutive sampled cycles a new level must persist before acceptance; legal ≥1.
- CNT_W, 8, width of edge_cnt.
- INIT, 0, reset value of synchronizer flops and level.

Ports:
- real_clk  input  1  clock, rising edge.
- real_rst  input  1  reset, asynchronous, active-high.
- pin_in  input  1  raw pad level, asynchronous to real_clk.
- en  input  1  debounce enable.
- clr_cnt  input  1  synchronous clear of edge_cnt.
- level  output  1  debounced level.
- rise  output  1  one-cycle pulse on accepted 0→1.
- fall  output  1  one-cycle pulse on accepted 1→0.
- edge_cnt  output  CNT_W  count of accepted transitions, saturating.
- busy  output  1  high while the stability counter is non-zero.

Behaviour:
Reset (real_rst high, asynchronous): all outputs take these values immediately and hold until real_rst deasserts:
- sync flops = INIT, level = INIT
- stability counter = 0, rise = fall = 0
- edge_cnt = 0, busy = 0

Synchronizer:
- SYNC_STAGES-deep shift register clocked by real_clk; s_out is the last stage.
- It runs regardless of en.
- No logic other than the next flop taps the first stage.

Stability counter: width clog2(DEBOUNCE_CYCLES+1). Evaluated on each rising edge using the pre-edge values of s_out and level:
- en=0: counter←0; level holds; rise=fall=0.
- en=1, s_out==level: counter←0.
- en=1, s_out!=level, counter<DEBOUNCE_CYCLES-1: counter←counter+1.
- en=1, s_out!=level, counter==DEBOUNCE_CYCLES-1: level←s_out; counter←0; rise←s_out; fall←~s_out.

Strobes:
- rise and fall are registered, high for exactly one cycle, and never high together.
- They are 0 on every edge that does not update level.

Latency:
- Let the first edge that samples the new pin value be edge 1.
- level changes on edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 6).
- rise/fall are high in the cycle after that edge.

Glitch rejection:
- A pin excursion sampled on fewer than DEBOUNCE_CYCLES consecutive edges never changes level.
- Any sample matching level restarts the count from 0.

busy:
- Combinational: (counter != 0).

edge_cnt (per edge, in priority order):
- clr_cnt=1 → 0, even if a strobe is generated on the same edge; that transition is not counted.
- Otherwise, an accepted transition → +1, saturating at 2^CNT_W-1 (no wrap).

en deassert mid-count:
- Counter is discarded.
- After re-enable, counting starts from 0.
- level is not re-evaluated until DEBOUNCE_CYCLES consecutive mismatches occur.

Reset mid-operation:
- Pending count lost; level returns to INIT.
- A pin held at ~INIT through reset is re-accepted with the full latency after release.

DEBOUNCE_CYCLES=1:
- level follows s_out with one register of delay.
- Every s_out change is accepted.

Test Plan:
- Defaults, en=1, pin 0→1 stable → level=1 and rise observed after edge 6 for one cycle only; edge_cnt=1; busy high for 3 cycles before acceptance.
- Pin high for 3 sampled edges then low → level stays 0, rise never asserts, edge_cnt=0, busy returns to 0.
- 10 clean toggles, each held 8 cycles, with CNT_W=3 → 5 rise and 5 fall pulses; edge_cnt saturates at 7 and holds; clr_cnt pulse → 0.
- clr_cnt asserted on the same edge a rise strobe is generated → edge_cnt=0 afterwards; rise still pulses; level=1.
- en dropped after counter reaches 2, pin held high, en restored 5 cycles later → level changes exactly 4 edges after en re-assertion, not earlier.
- real_rst asserted asynchronously mid-count with pin high, INIT=0 → outputs 0 immediately without a clock; after release, level=1 on edge 6 counted from the first post-reset edge.
